// File: rtl/assoc_wb_cache.sv
// 2-way set-associative, write-back, write-allocate data cache with per-set LRU,
// a req/ack word-wide memory port and a full write-back-and-invalidate flush.
module assoc_wb_cache #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CPU_read_en,
  input  logic              CPU_write_en,
  input  logic [ADDR_W-1:0] CPU_addr,
  input  logic [31:0]       CPU_write_din,
  output logic [31:0]       CPU_read_dout,
  output logic              isCacheStall,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int SETS   = 1 << INDEX_W;
  localparam int LINE_W = INDEX_W + OFFSET_W;
  localparam int SCAN_W = INDEX_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WBACK,
    S_FILL,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]         r_data  [2][1 << LINE_W];
  logic [TAG_W-1:0]    r_tag   [2][SETS];
  logic [SETS-1:0]     r_valid [2];
  logic [SETS-1:0]     r_dirty [2];
  logic [SETS-1:0]     r_lru;
  logic                r_victim;
  logic [OFFSET_W-1:0] r_word;
  // Flush pointer: bit 0 = way, next INDEX_W bits = set, top bit = past the end.
  logic [SCAN_W-1:0]   r_scan;

  logic                w_req;
  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic [OFFSET_W-1:0] w_off;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_victim;
  logic                w_victim_dirty;
  logic                w_last_word;
  logic                w_scan_way;
  logic [INDEX_W-1:0]  w_scan_set;
  logic                w_scan_end;
  logic                w_scan_last;
  logic                w_scan_dirty;
  logic                w_xfer_way;
  logic [INDEX_W-1:0]  w_xfer_set;
  logic                w_unused;

  assign w_unused = ^CPU_addr[1:0];

  assign w_req = CPU_read_en | CPU_write_en;
  assign w_tag = CPU_addr[ADDR_W-1 -: TAG_W];
  assign w_idx = CPU_addr[OFFSET_W+2 +: INDEX_W];
  assign w_off = CPU_addr[2 +: OFFSET_W];

  assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit     = (r_state == S_IDLE) && (w_hit0 || w_hit1);
  assign w_hit_way = w_hit1;

  // Invalid way first (way0 preferred), otherwise the least recently used one.
  assign w_victim = !r_valid[0][w_idx] ? 1'b0 :
                    (!r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx]);
  assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

  assign w_last_word  = &r_word;
  assign w_scan_way   = r_scan[0];
  assign w_scan_set   = r_scan[INDEX_W:1];
  assign w_scan_end   = r_scan[INDEX_W+1];
  assign w_scan_last  = &r_scan[INDEX_W:0];
  assign w_scan_dirty = !w_scan_end && r_valid[w_scan_way][w_scan_set] &&
                        r_dirty[w_scan_way][w_scan_set];

  assign w_xfer_way = (r_state == S_FLUSH_WB) ? w_scan_way : r_victim;
  assign w_xfer_set = (r_state == S_FLUSH_WB) ? w_scan_set : w_idx;

  assign isCacheStall  = w_req && !w_hit;
  assign CPU_read_dout = r_data[w_hit_way][{w_idx, w_off}];
  assign mem_wdata     = r_data[w_xfer_way][{w_xfer_set, r_word}];

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    flush_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          w_next = w_victim_dirty ? S_WBACK : S_FILL;
        end else if (!w_req && flush_req) begin
          w_next = S_FLUSH_SCAN;
        end
      end
      S_WBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {r_tag[r_victim][w_idx], w_idx, r_word, 2'b00};
        if (mem_ack && w_last_word) w_next = S_FILL;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, r_word, 2'b00};
        if (mem_ack && w_last_word) w_next = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        if (w_scan_dirty) begin
          w_next = S_FLUSH_WB;
        end else if (w_scan_end || w_scan_last) begin
          w_next     = S_IDLE;
          flush_done = 1'b1;
        end
      end
      S_FLUSH_WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {r_tag[w_scan_way][w_scan_set], w_scan_set, r_word, 2'b00};
        if (mem_ack && w_last_word) w_next = S_FLUSH_SCAN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_scan     <= '0;
      r_victim   <= 1'b0;
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_req && w_hit) begin
            r_lru[w_idx] <= ~w_hit_way;
            if (CPU_write_en) r_dirty[w_hit_way][w_idx] <= 1'b1;
          end else if (w_req) begin
            r_victim <= w_victim;
            r_word   <= '0;
          end else if (flush_req) begin
            r_scan <= '0;
          end
        end
        S_WBACK: begin
          if (mem_ack) r_word <= r_word + OFFSET_W'(1);
        end
        S_FILL: begin
          if (mem_ack) begin
            r_word <= r_word + OFFSET_W'(1);
            if (w_last_word) begin
              r_valid[r_victim][w_idx] <= 1'b1;
              r_dirty[r_victim][w_idx] <= 1'b0;
              r_lru[w_idx]             <= ~r_victim;
            end
          end
        end
        S_FLUSH_SCAN: begin
          if (w_scan_dirty) begin
            r_word <= '0;
          end else if (w_scan_end || w_scan_last) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
            r_lru      <= '0;
            r_scan     <= '0;
          end else begin
            r_scan <= r_scan + SCAN_W'(1);
          end
        end
        S_FLUSH_WB: begin
          if (mem_ack) begin
            r_word <= r_word + OFFSET_W'(1);
            if (w_last_word) r_scan <= r_scan + SCAN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays: synchronous write only, never reset.
  always_ff @(posedge clk) begin
    if (w_hit && w_req && CPU_write_en) begin
      r_data[w_hit_way][{w_idx, w_off}] <= CPU_write_din;
    end
    if ((r_state == S_FILL) && mem_ack) begin
      r_data[r_victim][{w_idx, r_word}] <= mem_rdata;
      if (w_last_word) r_tag[r_victim][w_idx] <= w_tag;
    end
  end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Scoreboard bench for assoc_wb_cache: a flat CPU-view memory plus a per-set
// recency list predicts hits, evictions, memory traffic and read data.
module tb_assoc_wb_cache;
  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 3;
  localparam int WORDS    = 8;
  localparam int MEMW     = 4096;

  logic              clk;
  logic              rst;
  logic              CPU_read_en;
  logic              CPU_write_en;
  logic [ADDR_W-1:0] CPU_addr;
  logic [31:0]       CPU_write_din;
  logic [31:0]       CPU_read_dout;
  logic              isCacheStall;
  logic              flush_req;
  logic              flush_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  assoc_wb_cache #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rst(rst),
    .CPU_read_en(CPU_read_en), .CPU_write_en(CPU_write_en),
    .CPU_addr(CPU_addr), .CPU_write_din(CPU_write_din),
    .CPU_read_dout(CPU_read_dout), .isCacheStall(isCacheStall),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct { logic [31:0] addr; bit we; logic [31:0] data; } mem_exp_t;
  typedef struct { bit chk_rd; logic [31:0] rdata; int stall; } cpu_exp_t;
  typedef struct { int set; int tag; bit dirty; } line_t;

  mem_exp_t    mem_q[$];
  cpu_exp_t    cpu_q[$];
  line_t       cache_q[$];   // most recently used first
  logic [31:0] backing [MEMW];
  logic [31:0] view    [MEMW];

  int checks = 0;
  int errors = 0;
  int lat_mode = 1;          // 0 zero-wait, 1 one wait state, 2 random 0..2
  bit in_flush = 0;
  int wr_count = 0;
  int done_pulses = 0;
  int stall_cnt = 0;
  int rsp_cnt = 0;
  int rsp_target = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: decides ack for the coming edge at posedge+2.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (rsp_cnt == 0)
          rsp_target = (lat_mode == 0) ? 0 : (lat_mode == 1) ? 1 : int'($urandom_range(0, 2));
        if (rsp_cnt >= rsp_target) begin
          mem_ack = 1'b1;
          if (mem_we) backing[mem_addr[13:2]] = mem_wdata;
          else        mem_rdata = backing[mem_addr[13:2]];
          rsp_cnt = 0;
        end else begin
          rsp_cnt++;
        end
      end
    end
  end

  // Memory-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && mem_ack) begin
        int idx;
        idx = -1;
        if (mem_we) wr_count++;
        if (mem_q.size() > 0 && mem_q[0].addr == mem_addr && mem_q[0].we == mem_we) begin
          idx = 0;
        end else if (in_flush) begin
          for (int i = 0; i < mem_q.size(); i++)
            if (idx < 0 && mem_q[i].addr == mem_addr && mem_q[i].we == mem_we) idx = i;
        end
        if (idx < 0) begin
          checks++;
          errors++;
          $display("FAIL mem_xfer actual addr=%h we=%0d required addr=%h we=%0d (queued %0d)",
                   mem_addr, mem_we, (mem_q.size() > 0) ? mem_q[0].addr : 32'hFFFF_FFFF,
                   (mem_q.size() > 0) ? mem_q[0].we : 1'b0, mem_q.size());
        end else begin
          chk("mem_xfer_addr", mem_addr, mem_q[idx].addr);
          if (mem_we) chk("mem_wdata", mem_wdata, mem_q[idx].data);
          mem_q.delete(idx);
        end
      end
      if (flush_done) done_pulses++;
    end
  end

  // CPU-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (CPU_read_en || CPU_write_en)) begin
        if (isCacheStall) begin
          stall_cnt++;
        end else begin
          if (cpu_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cpu_unexpected actual addr=%h required none", CPU_addr);
          end else begin
            cpu_exp_t e;
            e = cpu_q.pop_front();
            if (e.chk_rd) chk("read_data", CPU_read_dout, e.rdata);
            if (e.stall >= 0) chk("stall_cycles", stall_cnt, e.stall);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  function automatic logic [31:0] line_addr(int s, int t, int k);
    return 32'((t << 11) | (s << 5) | (k << 2));
  endfunction

  task automatic push_line(input int s, input int t, input bit we);
    for (int k = 0; k < WORDS; k++) begin
      mem_exp_t m;
      m.addr = line_addr(s, t, k);
      m.we   = we;
      m.data = we ? view[m.addr[13:2]] : 32'h0;
      mem_q.push_back(m);
    end
  endtask

  task automatic model_access(input bit re, input bit we, input logic [31:0] addr,
                              input logic [31:0] data);
    int w, s, t, pos, n, old;
    cpu_exp_t e;
    line_t l;
    w = int'(addr[13:2]);
    s = int'(addr[10:5]);
    t = int'(addr[13:11]);
    pos = -1;
    n = 0;
    old = -1;
    for (int i = 0; i < cache_q.size(); i++) begin
      if (cache_q[i].set == s) begin
        n++;
        old = i;
        if (cache_q[i].tag == t) pos = i;
      end
    end
    e.chk_rd = re;
    e.rdata  = view[w];
    if (pos >= 0) begin
      l = cache_q[pos];
      cache_q.delete(pos);
      if (we) l.dirty = 1'b1;
      cache_q.push_front(l);
      e.stall = 0;
    end else begin
      bit wb;
      wb = 1'b0;
      if (n == 2) begin
        l = cache_q[old];
        cache_q.delete(old);
        if (l.dirty) begin
          wb = 1'b1;
          push_line(l.set, l.tag, 1'b1);
        end
      end
      push_line(s, t, 1'b0);
      l.set = s;
      l.tag = t;
      l.dirty = we;
      cache_q.push_front(l);
      e.stall = (lat_mode == 0) ? (wb ? 2 * WORDS + 1 : WORDS + 1) : -1;
    end
    if (we) view[w] = data;
    cpu_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the access completes.
  task automatic access(input bit re, input bit we, input logic [31:0] addr,
                        input logic [31:0] data);
    int n;
    bit done;
    model_access(re, we, addr, data);
    CPU_addr      = addr;
    CPU_read_en   = re;
    CPU_write_en  = we;
    CPU_write_din = data;
    n = 0;
    done = 1'b0;
    while (!done && n < 500) begin
      @(negedge clk);
      if (!isCacheStall) done = 1'b1;
      else n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout actual=stalled required=complete addr=%h", addr);
    end
    @(posedge clk);
    #1;
    CPU_read_en  = 1'b0;
    CPU_write_en = 1'b0;
  endtask

  task automatic do_flush();
    int ndirty, wr0, p0, n;
    bit seen;
    ndirty = 0;
    for (int i = 0; i < cache_q.size(); i++) begin
      if (cache_q[i].dirty) begin
        ndirty++;
        push_line(cache_q[i].set, cache_q[i].tag, 1'b1);
      end
    end
    cache_q.delete();
    in_flush = 1'b1;
    wr0 = wr_count;
    p0 = done_pulses;
    flush_req = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout actual=no flush_done required=flush_done");
    end
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    repeat (4) @(negedge clk);
    in_flush = 1'b0;
    chk("flush_writes", wr_count - wr0, ndirty * WORDS);
    chk("flush_done_pulses", done_pulses - p0, 1);
    chk("flush_queue_drained", mem_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_during_fill(input logic [31:0] addr);
    int acks, n;
    for (int k = 0; k < 3; k++) begin
      mem_exp_t m;
      m.addr = {addr[31:5], 5'b0} | 32'(k << 2);
      m.we   = 1'b0;
      m.data = 32'h0;
      mem_q.push_back(m);
    end
    CPU_addr    = addr;
    CPU_read_en = 1'b1;
    acks = 0;
    n = 0;
    while (acks < 3 && n < 200) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
      n++;
    end
    if (acks < 3) begin
      checks++;
      errors++;
      $display("FAIL fill_ack_timeout actual=%0d required=3", acks);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    CPU_read_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_stall", isCacheStall, 1'b0);
    stall_cnt = 0;
    cache_q.delete();
    for (int i = 0; i < MEMW; i++) view[i] = backing[i];
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < MEMW; i++) begin
      backing[i] = 32'h5A00_0000 ^ 32'(i * 66051);
      view[i]    = backing[i];
    end
    rst = 1'b1;
    CPU_read_en = 1'b0;
    CPU_write_en = 1'b0;
    CPU_addr = '0;
    CPU_write_din = '0;
    flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", isCacheStall, 1'b0);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_flush_done", flush_done, 1'b0);
    @(posedge clk);
    #1;

    // Cold fill with one wait state, then hit, write hit, readback.
    lat_mode = 1;
    access(1, 0, 32'h104, 0);
    access(1, 0, 32'h110, 0);
    access(0, 1, 32'h104, 32'hDEAD_BEEF);
    access(1, 0, 32'h104, 0);
    // Three tags in set 8: eviction and LRU order.
    access(1, 0, 32'h904, 0);
    access(1, 0, 32'h1104, 0);
    repeat (3) access(1, 0, 32'h904, 0);
    access(1, 0, 32'h104, 0);
    access(1, 0, 32'h1104, 0);
    access(1, 1, 32'h108, 32'h1234_5678);
    // Zero-wait memory: exact stall lengths for clean and dirty misses.
    lat_mode = 0;
    access(1, 0, 32'h904, 0);
    access(1, 0, 32'h1108, 0);
    do_flush();
    access(0, 1, 32'h200, 32'hA5A5_0001);
    access(0, 1, 32'h400, 32'hA5A5_0002);
    do_flush();
    access(1, 0, 32'h200, 0);
    access(1, 0, 32'h400, 0);
    lat_mode = 1;
    reset_during_fill(32'h2284);
    access(1, 0, 32'h2284, 0);

    for (int it = 0; it < 400; it++) begin
      logic [31:0] a;
      int op;
      lat_mode = int'($urandom_range(0, 2));
      a = line_addr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, WORDS - 1)));
      op = int'($urandom_range(0, 7));
      if (op < 4)      access(1, 0, a, 0);
      else if (op < 7) access(0, 1, a, $urandom);
      else             access(1, 1, a, $urandom);
      if (it % 100 == 99) do_flush();
    end

    repeat (5) @(negedge clk);
    chk("final_mem_queue", mem_q.size(), 0);
    chk("final_cpu_queue", cpu_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU MEM stage and a word-wide main-memory port.
- Successor to the direct-mapped cache. Adds:
  - configurable sets and line size;
  - two ways with LRU replacement;
  - a req/ack memory handshake tolerating arbitrary wait states;
  - a full cache flush.
- Tag/data arrays are distributed RAM (asynchronous read, synchronous write).

Parameters:
- ADDR_W, 32: CPU byte-address width.
- INDEX_W, 6: set-index bits; SETS = 2**INDEX_W.
- OFFSET_W, 3: word-offset bits; WORDS = 2**OFFSET_W words per line.
- TAG_W = ADDR_W-INDEX_W-OFFSET_W-2: derived tag width, not overridable.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- CPU_read_en  in  1  load request
- CPU_write_en  in  1  store request
- CPU_addr  in  ADDR_W  byte address; bits[1:0] ignored
- CPU_write_din  in  32  store data
- CPU_read_dout  out  32  load data, valid when access is requested and isCacheStall=0
- isCacheStall  out  1  CPU must hold request and address stable while high
- flush_req  in  1  level; request write-back of all dirty lines plus invalidate
- flush_done  out  1  one-cycle pulse when flush completes
- mem_req  out  1  memory word transfer request
- mem_we  out  1  1 = write word, 0 = read word
- mem_addr  out  ADDR_W  word-aligned byte address (bits[1:0]=0)
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, sampled on mem_ack
- mem_ack  in  1  transfer complete; may be asserted in the first mem_req cycle

Behaviour:
- Address split:
  - tag = CPU_addr[ADDR_W-1 : ADDR_W-TAG_W];
  - index = next INDEX_W bits;
  - offset = next OFFSET_W bits.
- Per set, per way: valid, dirty, tag. Per set: one LRU bit, which names the way to evict next.
- Hit:
  - state == IDLE, the way's valid bit is set and its tag matches, evaluated combinationally.
  - Both ways matching cannot occur.
- isCacheStall = (CPU_read_en | CPU_write_en) & ~(state==IDLE & hit). It is 0 when there is no request.
- Read hit: CPU_read_dout = hit way word, zero wait states.
- Write hit: at the clock edge, the word is written, dirty set, and LRU points to the other way.
- Read and write both asserted: treated as a write. CPU_read_dout shows the pre-write word.
- Miss victim selection, fixed in the IDLE cycle the miss is detected:
  - an invalid way, way0 preferred;
  - else the LRU way.
- States: IDLE, WBACK, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - A miss with a dirty victim goes to WBACK; a clean victim goes to FILL.
  - With no CPU request and flush_req=1, go to FLUSH_SCAN. A CPU access takes priority over a flush.
- WBACK:
  - Writes victim words 0..WORDS-1 to {victim tag, index, word, 2'b00}.
  - mem_req=mem_we=1 is held per word until mem_ack; the next word is presented the following cycle.
  - After the last ack, go to FILL.
- FILL:
  - Reads words 0..WORDS-1 of the missed line; each mem_rdata is written on its ack.
  - After the last ack: valid=1, dirty=0, tag set, LRU points to the other way; go to IDLE.
  - The access then hits in IDLE. A pending write completes there and sets dirty.
- Zero-wait memory (ack in the first req cycle), misses reported by isCacheStall:
  - clean miss stalls WORDS+1 cycles;
  - dirty miss stalls 2*WORDS+1 cycles.
- FLUSH_SCAN:
  - Walks set 0..SETS-1, way0 then way1, one line per cycle.
  - A valid+dirty line goes to FLUSH_WB; on return, scanning resumes at the next line.
  - After the last line, clear all valid/dirty/LRU, pulse flush_done for one cycle, go to IDLE.
- FLUSH_WB: same transfer as WBACK, returns to FLUSH_SCAN.
- During a flush, any CPU request stalls. flush_req must drop after flush_done; if still high in IDLE, a new flush starts.
- mem_req is 0 in IDLE and FLUSH_SCAN. mem_we=0 in FILL. mem_wdata is don't-care when mem_we=0.
- Reset values:
  - state IDLE; all valid/dirty/LRU 0;
  - mem_req 0, mem_we 0, flush_done 0;
  - word counters 0, scan pointer 0.
- Reset mid-operation: an in-flight transfer is abandoned and dirty data is lost. mem_req is 0 in the cycle after reset is sampled.
- Illegal input: changing CPU_addr or enables while stalled is not supported, and the resulting behaviour is undefined.

Test Plan:
- Cold read of 0x0000_0104 with WORDS=8 and mem_ack one cycle after each req:
  - 8 reads at 0x100..0x11C;
  - afterwards, a read of 0x0000_0110 returns memory[0x110] with isCacheStall=0.
- Write hit to 0x104 with data 0xDEADBEEF:
  - same-cycle no stall;
  - a following read returns 0xDEADBEEF;
  - no memory write occurs.
- Tags A, B, C mapping to the same set:
  - A (dirty) and B fill way0 and way1;
  - access to C evicts A: 8 writes of A's line including 0xDEADBEEF, then 8 reads of C.
- Repeated access on B, then C again after an A miss:
  - LRU evicts the least recent line; no writeback if clean.
- Two dirty lines in different sets, then flush_req=1:
  - exactly 16 memory writes;
  - flush_done pulses once;
  - next read of either line misses.
- rst asserted on the 3rd ack of a FILL:
  - next cycle mem_req=0 and isCacheStall=0 with no request;
  - re-read misses and fully refills.
